// File: rtl/dmac_intf_param_if.sv
// AHB-Lite slave-side bus bundle for the DMA controller register file.
// The master modport drives the request side, the slave modport drives the response.
interface dmac_intf_param_if;
    logic        HSEL;
    logic        HREADY;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/dmac_intf_param.sv
// AHB-Lite register file for an NUM_CH-channel DMA engine: CTRL/SRC/DST/STATUS per channel, W1C INT_STAT, INT_EN, irq.
// Optional macro DMAC_ALIGN_CHECK_EN: mapped accesses that are not aligned 32-bit words take the ERROR path.
//
// state   | meaning
// ST_IDLE | zero-wait operation, OKAY responses
// ST_ERR1 | first ERROR cycle of an unmapped access (HREADYOUT=0, HRESP=1)
// ST_ERR2 | second ERROR cycle (HREADYOUT=1, HRESP=1)
module dmac_intf_param #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          NUM_CH    = 4,
    parameter int          SIZE_W    = 10
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    dmac_intf_param_if.slave         ahb,
    output logic [NUM_CH-1:0]        ch_en,
    output logic [NUM_CH-1:0]        ch_target,
    output logic [NUM_CH*SIZE_W-1:0] ch_size,
    output logic [NUM_CH*32-1:0]     ch_sour,
    output logic [NUM_CH*32-1:0]     ch_dest,
    input  logic [NUM_CH-1:0]        ch_done,
    input  logic [NUM_CH-1:0]        ch_busy,
    output logic [NUM_CH-1:0]        ch_abort,
    output logic                     irq
);
    localparam logic [31:0] CH_SPAN  = 32'(NUM_CH * 16);
    localparam logic [6:0]  W_ISTAT  = 7'h40;
    localparam logic [6:0]  W_INTEN  = 7'h41;

    typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;
    state_t state_q, state_d;

    logic [NUM_CH-1:0] en_q, en_d, tgt_q, tgt_d, stat_q, stat_d, ien_q, ien_d, abort_d;
    logic [SIZE_W-1:0] size_q [NUM_CH];
    logic [SIZE_W-1:0] size_d [NUM_CH];
    logic [31:0]       src_q  [NUM_CH];
    logic [31:0]       src_d  [NUM_CH];
    logic [31:0]       dst_q  [NUM_CH];
    logic [31:0]       dst_d  [NUM_CH];

    logic        access, a_mapped, wr_q;
    logic [31:0] offset, rdata_d;
    logic [6:0]  a_word, wr_word_q;
    logic        unused_bits;

    assign access      = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1] & (state_q != ST_ERR1);
    assign offset      = ahb.HADDR - BASE_ADDR;
    assign a_word      = offset[8:2];
    assign unused_bits = ^{ahb.HSIZE, ahb.HTRANS[0]};

    always_comb begin
        a_mapped = (offset < CH_SPAN) || (offset[31:3] == 29'h20);
`ifdef DMAC_ALIGN_CHECK_EN
        if (ahb.HSIZE != 3'b010 || ahb.HADDR[1:0] != 2'b00) begin
            a_mapped = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d = ST_IDLE;
        if (access && !a_mapped) begin
            state_d = ST_ERR1;
        end else if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end
    end

    assign ahb.HREADYOUT = (state_q != ST_ERR1);
    assign ahb.HRESP     = (state_q != ST_IDLE);

    // Data-phase write; an engine done clears EN first so a same-cycle CTRL write overrides it.
    always_comb begin
        en_d    = en_q & ~ch_done;
        tgt_d   = tgt_q;
        size_d  = size_q;
        src_d   = src_q;
        dst_d   = dst_q;
        stat_d  = stat_q;
        ien_d   = ien_q;
        abort_d = '0;
        if (wr_q) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_word_q[6:2] == 5'(i)) begin
                    case (wr_word_q[1:0])
                        2'd0: begin
                            en_d[i]    = ahb.HWDATA[0];
                            abort_d[i] = en_q[i] & ~ahb.HWDATA[0] & ch_busy[i];
                            if (!ch_busy[i]) begin
                                tgt_d[i]  = ahb.HWDATA[4];
                                size_d[i] = ahb.HWDATA[8 +: SIZE_W];
                            end
                        end
                        2'd1: if (!ch_busy[i]) src_d[i] = ahb.HWDATA;
                        2'd2: if (!ch_busy[i]) dst_d[i] = ahb.HWDATA;
                        default: ;
                    endcase
                end
            end
            if (wr_word_q == W_ISTAT) stat_d = stat_q & ~ahb.HWDATA[NUM_CH-1:0];
            if (wr_word_q == W_INTEN) ien_d  = ahb.HWDATA[NUM_CH-1:0];
        end
        stat_d = stat_d | ch_done;
    end

    // Reads decode the post-edge register values, which gives write-data bypass for free.
    always_comb begin
        rdata_d = '0;
        if (access && a_mapped && !ahb.HWRITE) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (a_word[6:2] == 5'(i)) begin
                    case (a_word[1:0])
                        2'd0:    rdata_d = 32'({size_d[i], 3'b000, tgt_d[i], 3'b000, en_d[i]});
                        2'd1:    rdata_d = src_d[i];
                        2'd2:    rdata_d = dst_d[i];
                        default: rdata_d = {30'd0, stat_d[i], ch_busy[i]};
                    endcase
                end
            end
            if (a_word == W_ISTAT) rdata_d = 32'(stat_d);
            if (a_word == W_INTEN) rdata_d = 32'(ien_d);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            wr_q       <= 1'b0;
            wr_word_q  <= '0;
            en_q       <= '0;
            tgt_q      <= '0;
            stat_q     <= '0;
            ien_q      <= '0;
            ch_abort   <= '0;
            irq        <= 1'b0;
            ahb.HRDATA <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                size_q[i] <= '0;
                src_q[i]  <= '0;
                dst_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_q       <= access & a_mapped & ahb.HWRITE;
            wr_word_q  <= a_word;
            en_q       <= en_d;
            tgt_q      <= tgt_d;
            stat_q     <= stat_d;
            ien_q      <= ien_d;
            size_q     <= size_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            ch_abort   <= abort_d;
            irq        <= |(stat_q & ien_q);
            ahb.HRDATA <= rdata_d;
        end
    end

    assign ch_en     = en_q;
    assign ch_target = tgt_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign ch_size[g*SIZE_W +: SIZE_W] = size_q[g];
        assign ch_sour[g*32 +: 32]         = src_q[g];
        assign ch_dest[g*32 +: 32]         = dst_q[g];
    end
endmodule
